// File: rtl/tick_timer_scheduler.sv
// tick_timer_scheduler: shares one prescaled interval timer among N_REQ
// requesters using round-robin arbitration. A granted requester holds the
// timer for its latched duration (in ticks) and receives a one-cycle done.
// Optional build macro SCHED_ABORT_EN: the granted requester dropping its
// request during RUN returns the scheduler to IDLE without a done pulse.
module tick_timer_scheduler #(
    parameter int N_REQ    = 4,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 50000000
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic [N_REQ-1:0]       iReq,
    input  logic [N_REQ*DUR_W-1:0] iDur,
    output logic [N_REQ-1:0]       oGnt,
    output logic [N_REQ-1:0]       oDone,
    output logic                   oTick,
    output logic                   oBusy
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_n;
    logic [PRE_W-1:0]   pre, pre_n;
    logic [DUR_W-1:0]   rem, rem_n;
    logic [PTR_W-1:0]   ptr, ptr_n;
    logic [N_REQ-1:0]   gnt_n, done_n;
    logic               tick_n, busy_n;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx, cand;
    logic [N_REQ-1:0]   win_hot;
    logic [DUR_W-1:0]   win_dur;

    // Round-robin search: first set request at or after the pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!win_found && iReq[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Winner's one-hot grant and duration field.
    always_comb begin
        win_hot = '0;
        win_dur = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_hot[i] = 1'b1;
                win_dur    = iDur[i*DUR_W +: DUR_W];
            end
        end
    end

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        state_n = state;
        pre_n   = pre;
        rem_n   = rem;
        ptr_n   = ptr;
        gnt_n   = oGnt;
        done_n  = '0;
        tick_n  = 1'b0;
        case (state)
            IDLE: begin
                gnt_n = '0;
                if (win_found) begin
                    gnt_n   = win_hot;
                    rem_n   = win_dur;
                    pre_n   = '0;
                    ptr_n   = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
                    state_n = (win_dur == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (pre == PRE_MAX) begin
                    pre_n = '0;
                    rem_n = rem - DUR_W'(1);
                    if (rem == DUR_W'(1)) state_n = DONE;
                end else begin
                    pre_n = pre + PRE_W'(1);
                end
`ifdef SCHED_ABORT_EN
                // Granted requester withdrew: abandon the interval silently.
                if ((iReq & oGnt) == '0) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                end
`endif
            end
            DONE: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
        // Registered tick mirrors "in RUN with prescaler at its last count".
        if (state_n == DONE) done_n = gnt_n;
        if (state_n == RUN)  tick_n = (pre_n == PRE_MAX);
        busy_n = (state_n != IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
            pre   <= '0;
            rem   <= '0;
            ptr   <= '0;
            oGnt  <= '0;
            oDone <= '0;
            oTick <= 1'b0;
            oBusy <= 1'b0;
        end else begin
            state <= state_n;
            pre   <= pre_n;
            rem   <= rem_n;
            ptr   <= ptr_n;
            oGnt  <= gnt_n;
            oDone <= done_n;
            oTick <= tick_n;
            oBusy <= busy_n;
        end
    end
endmodule

// File: tb/tb_tick_timer_scheduler.sv
// Bench for tick_timer_scheduler: interval-level reference model (grant
// cycle, duration, owner) checked every cycle, directed literal cases, and
// randomized request traffic. A second instance covers TICK_DIV=1.
module tb_tick_timer_scheduler;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TD = 4;

    logic            iClk = 1'b0;
    logic            iRst;
    logic [N-1:0]    iReq;
    logic [N*DW-1:0] iDur;
    logic [N-1:0]    oGnt, oDone;
    logic            oTick, oBusy;

    logic            rst1;
    logic [N-1:0]    req1;
    logic [N*DW-1:0] dur1;
    logic [N-1:0]    gnt1, done1;
    logic            tick1, busy1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 iClk = ~iClk;

    tick_timer_scheduler #(.N_REQ(N), .DUR_W(DW), .TICK_DIV(TD)) u_dut (
        .iClk(iClk), .iRst(iRst), .iReq(iReq), .iDur(iDur),
        .oGnt(oGnt), .oDone(oDone), .oTick(oTick), .oBusy(oBusy));

    tick_timer_scheduler #(.N_REQ(N), .DUR_W(DW), .TICK_DIV(1)) u_dut1 (
        .iClk(iClk), .iRst(rst1), .iReq(req1), .iDur(dur1),
        .oGnt(gnt1), .oDone(done1), .oTick(tick1), .oBusy(busy1));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- reference model (interval view) ----------------
    bit   m_act = 0;
    int   m_own, m_g, m_d, m_ptr = 0;
    bit   chk_en = 0;
    logic [N-1:0] e_gnt = '0, e_done = '0;
    logic e_tick = 0, e_busy = 0;

    always @(posedge iClk) begin
        int n, dc, m;
        bit got;
        n = cyc;
        if (iRst) begin
            m_act  = 0;
            m_ptr  = 0;
            chk_en = 1;
        end else begin
            dc = m_g + m_d * TD + 1;
            if (!m_act || n > dc) begin
                m_act = 0;
                got   = 0;
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (!got && iReq[idx]) begin
                        got   = 1;
                        m_act = 1;
                        m_own = idx;
                        m_g   = n;
                        m_d   = int'((iDur >> (idx * DW)) & 32'hFF);
                        m_ptr = (idx + 1) % N;
                    end
                end
            end
`ifdef SCHED_ABORT_EN
            else if (n >= m_g + 1 && n <= m_g + m_d * TD && !iReq[m_own]) begin
                m_act = 0;
            end
`endif
        end
        cyc = cyc + 1;
        m = cyc;
        dc = m_g + m_d * TD + 1;
        e_gnt = '0; e_done = '0; e_tick = 0; e_busy = 0;
        if (m_act && m >= m_g + 1 && m <= dc) begin
            e_gnt[m_own] = 1'b1;
            e_busy       = 1;
            if (m == dc) e_done[m_own] = 1'b1;
            if (m <= dc - 1 && ((m - m_g) % TD) == 0) e_tick = 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge iClk) begin
        if (chk_en) begin
            chk("gnt", oGnt, e_gnt);
            chk("done", oDone, e_done);
            chk("tick", oTick, e_tick);
            chk("busy", oBusy, e_busy);
            chk("gnt_onehot", ($countones(oGnt) <= 1), 1);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic set_dur(input int i, input int v);
        iDur[i*DW +: DW] = DW'(v);
    endtask

    initial begin
        int last, found, r;
        iRst = 1; iReq = '0; iDur = '0;
        rst1 = 1; req1 = '0; dur1 = '0;
        step(2);
        chk("rst_gnt", oGnt, 0);
        chk("rst_busy", oBusy, 0);
        iRst = 0; rst1 = 0;
        step(2);

        // T1: single request, duration 3
        iReq = 4'b0001; set_dur(0, 3);
        step(3);
        chk("t1_tick3", oTick, 0);
        chk("t1_gnt3", oGnt, 4'b0001);
        step(1);
        chk("t1_tick4", oTick, 1);
        step(8);
        chk("t1_tick12", oTick, 1);
        chk("t1_done12", oDone, 0);
        step(1);
        chk("t1_done13", oDone, 4'b0001);
        chk("t1_gnt13", oGnt, 4'b0001);
        iReq = '0;
        step(1);
        chk("t1_gnt14", oGnt, 0);
        chk("t1_busy14", oBusy, 0);
        step(2);

        // T3: zero duration goes straight to DONE
        iReq = 4'b0100; iDur = '0;
        step(1);
        chk("t3_gnt1", oGnt, 4'b0100);
        chk("t3_done1", oDone, 4'b0100);
        chk("t3_tick1", oTick, 0);
        iReq = '0;
        step(1);
        chk("t3_gnt2", oGnt, 0);
        chk("t3_busy2", oBusy, 0);
        step(2);

        // T4: request dropped mid-run; duration changed after grant is ignored
        iReq = 4'b0010; set_dur(1, 5);
        step(2);
        set_dur(1, 255);
        step(4);
        iReq = '0;
`ifdef SCHED_ABORT_EN
        step(1);
        chk("t4_abort_gnt7", oGnt, 0);
        chk("t4_abort_busy7", oBusy, 0);
        step(16);
`else
        step(14);
        chk("t4_gnt20", oGnt, 4'b0010);
        chk("t4_done20", oDone, 0);
        step(1);
        chk("t4_done21", oDone, 4'b0010);
        step(2);
`endif
        iDur = '0;

        // T5: reset mid-run clears outputs and round-robin pointer
        iReq = 4'b0001; set_dur(0, 5);
        step(5);
        iRst = 1;
        step(1);
        chk("t5_gnt", oGnt, 0);
        chk("t5_done", oDone, 0);
        chk("t5_tick", oTick, 0);
        chk("t5_busy", oBusy, 0);
        iRst = 0; iReq = 4'b1001;
        step(1);
        chk("t5_first_gnt", oGnt, 4'b0001);
        iReq = '0;
        step(26);

        // T2: all requesting, duration 1 each, from a fresh pointer
        iRst = 1;
        step(1);
        iRst = 0; iReq = 4'b1111;
        for (int i = 0; i < N; i++) set_dur(i, 1);
        last = 0;
        for (int g = 0; g < 5; g++) begin
            found = 0;
            for (int w = 0; w < 20 && !found; w++) begin
                step(1);
                if (oDone != 0) found = 1;
            end
            chk("t2_done_seen", found, 1);
            chk("t2_order", oDone, 4'b0001 << (g % N));
            if (g > 0) chk("t2_spacing", cyc - last, 6);
            last = cyc;
        end
        iReq = '0;
        step(3);

        // Randomized traffic; requesters hold until done
        for (int c = 0; c < 4000; c++) begin
            iRst = ($urandom_range(0, 799) == 0);
            for (int i = 0; i < N; i++) begin
                if (iReq[i] && oDone[i]) iReq[i] = 1'b0;
                else if (!iReq[i] && $urandom_range(0, 3) == 0) iReq[i] = 1'b1;
`ifdef SCHED_ABORT_EN
                else if (iReq[i] && $urandom_range(0, 59) == 0) iReq[i] = 1'b0;
`endif
                r = $urandom_range(0, 99);
                set_dur(i, (r < 2) ? 255 : (r < 12) ? 0 : $urandom_range(1, 6));
            end
            step(1);
        end
        iRst = 1; iReq = '0;
        step(2);
        iRst = 0;
        step(1);

        // T6: TICK_DIV=1 instance, full-scale duration
        req1 = 4'b0001; dur1 = '0; dur1[DW-1:0] = 8'hFF;
        for (int k = 1; k <= 255; k++) begin
            step(1);
            chk("t6_tick", tick1, 1);
            chk("t6_gnt", gnt1, 4'b0001);
            chk("t6_nodone", done1, 0);
        end
        step(1);
        chk("t6_done256", done1, 4'b0001);
        chk("t6_tick256", tick1, 0);
        req1 = '0;
        step(1);
        chk("t6_busy257", busy1, 0);
        chk("t6_gnt257", gnt1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
